instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// buffers returned words with their addresses, and flushes on redirect.
module instr_fetch_unit #(
  parameter logic [23:0] RESET_PC = 24'd10,
  parameter logic [23:0] PC_STEP  = 24'd3,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        mem_req_valid,
  output logic [23:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [23:0] mem_rsp_data,
  output logic        ins_valid,
  output logic [23:0] ins_data,
  output logic [23:0] ins_pc,
  input  logic        ins_ready,
  input  logic        redirect_valid,
  input  logic [23:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e        state_q;
  logic [23:0]   fetch_pc_q;
  logic [23:0]   req_pc_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [23:0]   pc_mem_q   [DEPTH];
  logic [23:0]   data_mem_q [DEPTH];

  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;

  // Reset gates the handshake outputs so they are quiet before state settles.
  always_comb begin
    mem_req_valid = 1'b0;
    ins_valid     = 1'b0;
    if (Reset) begin
      mem_req_valid = 1'b0;
      ins_valid     = 1'b0;
    end else begin
      mem_req_valid = (state_q == ST_FETCH) && (count_q < FULL_CNT);
      ins_valid     = (count_q != '0);
    end
  end

  // Head presentation and event qualification; redirect cancels push and pop.
  always_comb begin
    mem_req_addr = fetch_pc_q;
    ins_data     = 24'd0;
    ins_pc       = 24'd0;
    if (ins_valid) begin
      ins_data = data_mem_q[rd_ptr_q];
      ins_pc   = pc_mem_q[rd_ptr_q];
    end else begin
      ins_data = 24'd0;
      ins_pc   = 24'd0;
    end
    req_fire_s = mem_req_valid && mem_req_ready;
    push_s     = (state_q == ST_WAIT) && mem_rsp_valid && !redirect_valid;
    pop_s      = ins_valid && ins_ready && !redirect_valid;
  end

  // Fetch FSM and fetch address; a response in FETCH is ignored.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      case (state_q)
        ST_FETCH:            state_q <= req_fire_s ? ST_DISCARD : ST_FETCH;
        ST_WAIT, ST_DISCARD: state_q <= mem_rsp_valid ? ST_FETCH : ST_DISCARD;
        default:             state_q <= ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (req_fire_s) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            state_q    <= ST_WAIT;
          end else begin
            state_q    <= ST_FETCH;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (mem_rsp_valid) begin
            state_q <= ST_FETCH;
          end else begin
            state_q <= state_q;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Instruction buffer pointers and occupancy; storage needs no reset.
  always_ff @(posedge Clock) begin
    if (Reset || redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        data_mem_q[wr_ptr_q] <= mem_rsp_data;
        wr_ptr_q             <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory
// of programmable response latency that returns addr ^ 24'hC0FFEE.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        mem_req_valid;
  logic [23:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [23:0] mem_rsp_data  = 24'd0;
  logic        ins_valid;
  logic [23:0] ins_data;
  logic [23:0] ins_pc;
  logic        ins_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [23:0] redirect_pc = 24'd0;

  int          n_checks = 0;
  int          n_err    = 0;
  int          mem_lat  = 1;
  int          pend_cd  = 0;
  logic [23:0] pend_addr = 24'd0;

  localparam logic [6:0]  T1_REQV = 7'b1010101;
  localparam logic [6:0]  T1_INSV = 7'b1010100;
  localparam logic [23:0] T1_ADDR [7] = '{24'd10, 24'd0, 24'd13, 24'd0, 24'd16, 24'd0, 24'd19};
  localparam logic [23:0] T1_PC   [7] = '{24'd0, 24'd0, 24'd10, 24'd0, 24'd13, 24'd0, 24'd16};
  localparam logic [23:0] T6_ADDR [3] = '{24'hFFFFFE, 24'h000001, 24'h000004};

  instr_fetch_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 Clock = ~Clock;

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    return a ^ 24'hC0FFEE;
  endfunction

  task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; the memory model sees the request as settled at the
  // falling edge, and redirect is a one-cycle pulse.
  task automatic next_cycle();
    logic        acc;
    logic [23:0] a;
    logic        rst;
    @(negedge Clock);
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    rst = Reset;
    @(posedge Clock);
    #1;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 24'd0;
    if (rst) begin
      pend_cd = 0;
    end else begin
      if (acc) begin
        pend_cd   = mem_lat;
        pend_addr = a;
      end
      if (pend_cd == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_addr);
        pend_cd       = 0;
      end else if (pend_cd > 1) begin
        pend_cd--;
      end
    end
  endtask

  task automatic do_reset();
    Reset          = 1'b1;
    mem_req_ready  = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    mem_lat        = 1;
    next_cycle();
    next_cycle();
    check_val("rst_req_valid", {23'd0, mem_req_valid}, 24'd0);
    check_val("rst_ins_valid", {23'd0, ins_valid}, 24'd0);
    check_val("rst_ins_data", ins_data, 24'd0);
    check_val("rst_ins_pc", ins_pc, 24'd0);
    Reset = 1'b0;
    #1;
    check_val("post_rst_req_valid", {23'd0, mem_req_valid}, 24'd1);
    check_val("post_rst_req_addr", mem_req_addr, 24'd10);
    check_val("post_rst_ins_valid", {23'd0, ins_valid}, 24'd0);
  endtask

  task automatic wait_ins(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!ins_valid && n < max_cyc) begin
      next_cycle();
      n++;
    end
    check_val({tag, "_timeout"}, {23'd0, ins_valid}, 24'd1);
  endtask

  initial begin
    int          n_req;
    int          n_acc;
    logic [23:0] got_addr [3];

    // Streaming fetch with single-cycle memory and an always-ready decoder.
    do_reset();
    mem_req_ready = 1'b1;
    ins_ready     = 1'b1;
    for (int c = 0; c < 7; c++) begin
      check_val($sformatf("t1_req_v_c%0d", c), {23'd0, mem_req_valid}, {23'd0, T1_REQV[c]});
      if (T1_REQV[c]) check_val($sformatf("t1_req_a_c%0d", c), mem_req_addr, T1_ADDR[c]);
      check_val($sformatf("t1_ins_v_c%0d", c), {23'd0, ins_valid}, {23'd0, T1_INSV[c]});
      if (T1_INSV[c]) begin
        check_val($sformatf("t1_ins_pc_c%0d", c), ins_pc, T1_PC[c]);
        check_val($sformatf("t1_ins_d_c%0d", c), ins_data, mem_word(T1_PC[c]));
      end
      next_cycle();
    end

    // Stalled decoder fills the two-entry buffer, then drains.
    do_reset();
    mem_req_ready = 1'b1;
    ins_ready     = 1'b0;
    n_req = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_req_valid) n_req++;
      next_cycle();
    end
    check_val("t2_req_count", 24'(n_req), 24'd2);
    check_val("t2_full_req_v", {23'd0, mem_req_valid}, 24'd0);
    check_val("t2_hold_pc", ins_pc, 24'd10);
    check_val("t2_hold_data", ins_data, mem_word(24'd10));
    ins_ready = 1'b1;
    next_cycle();
    check_val("t2_resume_req_v", {23'd0, mem_req_valid}, 24'd1);
    check_val("t2_resume_addr", mem_req_addr, 24'd16);
    check_val("t2_second_pc", ins_pc, 24'd13);
    next_cycle();
    next_cycle();
    check_val("t2_third_pc", ins_pc, 24'd16);
    check_val("t2_third_data", ins_data, mem_word(24'd16));

    // Redirect while waiting on address 16 with a two-cycle memory.
    do_reset();
    mem_lat       = 2;
    mem_req_ready = 1'b1;
    ins_ready     = 1'b1;
    for (int c = 0; c < 6; c++) next_cycle();
    check_val("t3_req_addr16", mem_req_addr, 24'd16);
    next_cycle();
    check_val("t3_wait_req_v", {23'd0, mem_req_valid}, 24'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 24'h000100;
    next_cycle();
    check_val("t3_after_redir_ins_v", {23'd0, ins_valid}, 24'd0);
    check_val("t3_discard_req_v", {23'd0, mem_req_valid}, 24'd0);
    next_cycle();
    check_val("t3_refetch_addr", mem_req_addr, 24'h000100);
    wait_ins("t3_ins", 10);
    check_val("t3_ins_pc", ins_pc, 24'h000100);
    check_val("t3_ins_data", ins_data, mem_word(24'h000100));

    // Redirect coinciding with a response and a pop.
    do_reset();
    mem_req_ready = 1'b1;
    ins_ready     = 1'b0;
    next_cycle();
    next_cycle();
    check_val("t4_head_pc", ins_pc, 24'd10);
    next_cycle();
    check_val("t4_rsp_present", {23'd0, mem_rsp_valid}, 24'd1);
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 24'h000200;
    next_cycle();
    check_val("t4_flush_ins_v", {23'd0, ins_valid}, 24'd0);
    check_val("t4_fetch_req_v", {23'd0, mem_req_valid}, 24'd1);
    check_val("t4_fetch_addr", mem_req_addr, 24'h000200);
    wait_ins("t4_ins", 10);
    check_val("t4_ins_pc", ins_pc, 24'h000200);

    // Memory back-pressure keeps the address stable.
    do_reset();
    ins_ready     = 1'b1;
    mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_val($sformatf("t5_stall_v_c%0d", c), {23'd0, mem_req_valid}, 24'd1);
      check_val($sformatf("t5_stall_a_c%0d", c), mem_req_addr, 24'd10);
      next_cycle();
    end
    mem_req_ready = 1'b1;
    check_val("t5_accept_addr", mem_req_addr, 24'd10);
    next_cycle();
    next_cycle();
    check_val("t5_next_addr", mem_req_addr, 24'd13);
    check_val("t5_ins_pc", ins_pc, 24'd10);

    // Address wrap after a redirect near the top of the space.
    do_reset();
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 24'hFFFFFE;
    next_cycle();
    check_val("t6_redir_addr", mem_req_addr, 24'hFFFFFE);
    mem_req_ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 3; k++) got_addr[k] = 24'hBAD000;
    for (int c = 0; c < 12; c++) begin
      if (mem_req_valid && n_acc < 3) begin
        got_addr[n_acc] = mem_req_addr;
        n_acc++;
      end
      next_cycle();
    end
    check_val("t6_acc_count", 24'(n_acc), 24'd3);
    for (int k = 0; k < 3; k++) check_val($sformatf("t6_addr%0d", k), got_addr[k], T6_ADDR[k]);

    // A response while in FETCH must not enter the buffer.
    do_reset();
    mem_req_ready = 1'b0;
    ins_ready     = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 24'h123456;
    next_cycle();
    check_val("t7_stray_rsp_ins_v", {23'd0, ins_valid}, 24'd0);
    check_val("t7_stray_rsp_addr", mem_req_addr, 24'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
